// File: rtl/pattern_misr_harness_pkg.sv
// -----------------------------------------------------------------------------
// pattern_misr_harness_pkg
// Shared definitions for the pattern/MISR test harness:
//   - state_e    : harness FSM states (IDLE, RUN, DONE)
//   - MISR_POLY  : feedback polynomial of the 16-bit signature register
//   - LFSR_TAPS  : tap mask of the 4-bit maximal-length pattern LFSR
//                  (taps on bits 3 and 2, period 15, never emits 0)
// -----------------------------------------------------------------------------
package pattern_misr_harness_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [15:0] MISR_POLY = 16'h1021;
    localparam logic [3:0]  LFSR_TAPS = 4'b1100;

endpackage

// File: rtl/pattern_misr_harness_if.sv
// -----------------------------------------------------------------------------
// pattern_misr_harness_if
// Groups the control, pattern and result signals of the harness.
//   master : the environment (drives start/num_patterns/seed/resp_in)
//   slave  : the harness (drives pat_out/busy/done/signature/pat_count)
// Signals:
//   start        - begin a run (only honoured while idle)
//   num_patterns - patterns per run, captured at start
//   seed         - first pattern, captured at start
//   pat_out      - registered pattern applied to the circuit under test
//   resp_in      - circuit response to the current pat_out
//   busy         - high while compacting
//   done         - one-cycle end-of-run pulse
//   signature    - MISR state, stable outside a run
//   pat_count    - patterns compacted in the current or last run
// -----------------------------------------------------------------------------
interface pattern_misr_harness_if #(
    parameter int PAT_W  = 4,
    parameter int RESP_W = 6,
    parameter int SIG_W  = 16,
    parameter int CNT_W  = 8
);
    logic              start;
    logic [CNT_W-1:0]  num_patterns;
    logic [PAT_W-1:0]  seed;
    logic [PAT_W-1:0]  pat_out;
    logic [RESP_W-1:0] resp_in;
    logic              busy;
    logic              done;
    logic [SIG_W-1:0]  signature;
    logic [CNT_W-1:0]  pat_count;

    modport master (
        output start, num_patterns, seed, resp_in,
        input  pat_out, busy, done, signature, pat_count
    );

    modport slave (
        input  start, num_patterns, seed, resp_in,
        output pat_out, busy, done, signature, pat_count
    );
endinterface

// File: rtl/pattern_misr_harness_pattern_gen.sv
// -----------------------------------------------------------------------------
// pattern_gen
// Pattern register feeding the circuit under test.
// Configuration macro: HARNESS_EXHAUSTIVE_EN
//   undefined : Fibonacci LFSR, next = {p[2:0], p[3]^p[2]}; a zero seed is
//               replaced by 1 because 0 is the LFSR's lock-up state.
//   defined   : binary up-counter modulo 2^PAT_W starting at seed (0 allowed),
//               so every input combination is applied.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset (pattern -> 0)
//   load_i      - load the (sanitised) seed
//   advance_i   - step to the next pattern
//   seed_i      - seed value
//   pat_o       - current pattern
// -----------------------------------------------------------------------------
module pattern_gen
    import pattern_misr_harness_pkg::*;
#(
    parameter int PAT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             advance_i,
    input  logic [PAT_W-1:0] seed_i,
    output logic [PAT_W-1:0] pat_o
);

    logic [PAT_W-1:0] pat_q, pat_d;
    logic [PAT_W-1:0] next_pat;
    logic [PAT_W-1:0] seed_fix;

`ifdef HARNESS_EXHAUSTIVE_EN
    assign next_pat = pat_q + PAT_W'(1);
    assign seed_fix = seed_i;
`else
    localparam logic [PAT_W-1:0] TAPS = PAT_W'(LFSR_TAPS);

    assign next_pat = {pat_q[PAT_W-2:0], ^(pat_q & TAPS)};
    assign seed_fix = (seed_i == '0) ? PAT_W'(1) : seed_i;
`endif

    // NOTE: every output of a combinational block gets a default first, so no
    // path through it can leave a value unassigned and infer a latch.
    always_comb begin
        pat_d = pat_q;
        if (load_i) begin
            pat_d = seed_fix;
        end else if (advance_i) begin
            pat_d = next_pat;
        end
    end

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_q <= '0;
        end else begin
            pat_q <= pat_d;
        end
    end

    assign pat_o = pat_q;

endmodule

// File: rtl/pattern_misr_harness.sv
// -----------------------------------------------------------------------------
// pattern_misr_harness
// Applies a run of test patterns to a combinational circuit and compacts its
// responses into a MISR signature.
// Configuration macro: HARNESS_EXHAUSTIVE_EN (pattern source, see pattern_gen).
// Ports:
//   clk   - single clock, rising edge
//   rst_n - asynchronous active-low reset; aborts any run without a done
//   bus   - pattern_misr_harness_if.slave (start, num_patterns, seed, resp_in
//           in; pat_out, busy, done, signature, pat_count out)
// Operation:
//   IDLE : start with num_patterns != 0 captures the count, loads the seed and
//          clears the signature/count, then RUN; num_patterns == 0 clears and
//          goes straight to DONE.
//   RUN  : one compaction per cycle; leaves after the captured count.
//   DONE : one-cycle done pulse, back to IDLE.
// -----------------------------------------------------------------------------
module pattern_misr_harness
    import pattern_misr_harness_pkg::*;
#(
    parameter int PAT_W  = 4,
    parameter int RESP_W = 6,
    parameter int SIG_W  = 16,
    parameter int CNT_W  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    pattern_misr_harness_if.slave   bus
);

    localparam logic [SIG_W-1:0] POLY = SIG_W'(MISR_POLY);

    state_e           state_q, state_d;
    logic [SIG_W-1:0] sig_q, sig_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] num_q, num_d;
    logic             pat_load;
    logic             pat_advance;
    logic [SIG_W-1:0] sig_next;

    // Shift with polynomial feedback from the MSB, then fold in the response.
    assign sig_next = {sig_q[SIG_W-2:0], 1'b0}
                    ^ (sig_q[SIG_W-1] ? POLY : '0)
                    ^ SIG_W'(bus.resp_in);

    pattern_gen #(
        .PAT_W (PAT_W)
    ) u_pattern_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (pat_load),
        .advance_i (pat_advance),
        .seed_i    (bus.seed),
        .pat_o     (bus.pat_out)
    );

    always_comb begin
        state_d     = state_q;
        sig_d       = sig_q;
        cnt_d       = cnt_q;
        num_d       = num_q;
        pat_load    = 1'b0;
        pat_advance = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    sig_d = '0;
                    cnt_d = '0;
                    if (bus.num_patterns != '0) begin
                        num_d    = bus.num_patterns;
                        pat_load = 1'b1;
                        state_d  = ST_RUN;
                    end else begin
                        state_d  = ST_DONE;
                    end
                end
            end

            ST_RUN: begin
                sig_d       = sig_next;
                cnt_d       = cnt_q + CNT_W'(1);
                pat_advance = 1'b1;
                // Compare the incremented count so the last compaction and
                // the exit happen in the same cycle.
                if (cnt_d == num_q) begin
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sig_q   <= '0;
            cnt_q   <= '0;
            num_q   <= '0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
            num_q   <= num_d;
        end
    end

    // Status is decoded from the state register only, so reset clears it
    // immediately and an aborted run can never pulse done.
    assign bus.busy      = (state_q == ST_RUN);
    assign bus.done      = (state_q == ST_DONE);
    assign bus.signature = sig_q;
    assign bus.pat_count = cnt_q;

endmodule

// File: tb/tb_pattern_misr_harness.sv
// -----------------------------------------------------------------------------
// tb_pattern_misr_harness
// Directed runs of pattern_misr_harness. Stimulus pushes the expected pattern
// stream and the expected end-of-run result into queues; a monitor pops them
// as the DUT shows busy cycles and done pulses.
// Build with or without HARNESS_EXHAUSTIVE_EN (must match the RTL build).
// -----------------------------------------------------------------------------
module tb_pattern_misr_harness;

    localparam int PAT_W  = 4;
    localparam int RESP_W = 6;
    localparam int SIG_W  = 16;
    localparam int CNT_W  = 8;

    typedef struct {
        logic [SIG_W-1:0] sig;
        logic [CNT_W-1:0] cnt;
        int               busy_cycles;
    } run_exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    pattern_misr_harness_if #(
        .PAT_W (PAT_W), .RESP_W (RESP_W), .SIG_W (SIG_W), .CNT_W (CNT_W)
    ) bus ();

    pattern_misr_harness #(
        .PAT_W (PAT_W), .RESP_W (RESP_W), .SIG_W (SIG_W), .CNT_W (CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    run_exp_t         exp_runs[$];
    logic [PAT_W-1:0] exp_pats[$];
    int               n_checks = 0;
    int               n_fail   = 0;

    // Emulated circuit under test.
    function automatic logic [RESP_W-1:0] circuit(input logic [PAT_W-1:0] x);
        circuit = {x[3] & x[2], x[1] | x[0], x[3] ^ x[0], ~x[2],
                   (x[2] & x[1]) | x[0], ^x};
    endfunction

    function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] s,
                                                   input logic [RESP_W-1:0] r);
        logic [SIG_W-1:0] fb;
        fb = s[SIG_W-1] ? 16'h1021 : 16'h0000;
        misr_step = {s[SIG_W-2:0], 1'b0} ^ fb ^ {10'b0, r};
    endfunction

    logic              use_circuit = 1'b0;
    logic [RESP_W-1:0] resp_const  = '0;
    assign bus.resp_in = use_circuit ? circuit(bus.pat_out) : resp_const;

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s", name);
    endtask

    // Monitor: sample away from the active edge.
    initial begin : monitor
        int       busy_cnt;
        logic     prev_done;
        run_exp_t e;
        busy_cnt  = 0;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy_cnt  = 0;
                prev_done = 1'b0;
            end else begin
                if (bus.busy) begin
                    busy_cnt++;
                    if (exp_pats.size() == 0)
                        fail_now($sformatf("unexpected busy cycle, pat_out=%0h", bus.pat_out));
                    else
                        check("pat_out", 32'(bus.pat_out), 32'(exp_pats.pop_front()));
                end
                if (bus.done) begin
                    check("done single pulse", 32'(prev_done), 32'd0);
                    if (exp_runs.size() == 0) begin
                        fail_now("unexpected done pulse");
                    end else begin
                        e = exp_runs.pop_front();
                        check("signature", 32'(bus.signature), 32'(e.sig));
                        check("pat_count", 32'(bus.pat_count), 32'(e.cnt));
                        check("busy cycles", busy_cnt, e.busy_cycles);
                    end
                    busy_cnt = 0;
                end
                prev_done = bus.done;
            end
        end
    end

    // Issue start for one cycle, then scramble seed/num to prove they were latched.
    task automatic launch(input logic [PAT_W-1:0] s, input logic [CNT_W-1:0] n,
                          input logic [SIG_W-1:0] exp_sig, input bit push_exp);
        @(posedge clk);
        #1;
        bus.seed         = s;
        bus.num_patterns = n;
        bus.start        = 1'b1;
        if (push_exp)
            exp_runs.push_back('{sig: exp_sig, cnt: n, busy_cycles: int'(n)});
        @(posedge clk);
        #1;
        bus.start        = 1'b0;
        bus.seed         = PAT_W'($urandom);
        bus.num_patterns = CNT_W'($urandom);
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while ((exp_runs.size() != 0 || exp_pats.size() != 0) && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k >= 200) begin
            fail_now("timeout waiting for run to complete");
            exp_runs.delete();
            exp_pats.delete();
        end
        @(posedge clk);
        #1;
    endtask

`ifdef HARNESS_EXHAUSTIVE_EN
    logic [PAT_W-1:0] seq15 [15] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15};
    localparam logic [PAT_W-1:0] NEXT_AFTER_15 = 4'd0;
    logic [PAT_W-1:0] seq_seed0 [3] = '{0, 1, 2};
`else
    logic [PAT_W-1:0] seq15 [15] = '{1, 2, 4, 9, 3, 6, 13, 10, 5, 11, 7, 15, 14, 12, 8};
    localparam logic [PAT_W-1:0] NEXT_AFTER_15 = 4'd1;
    logic [PAT_W-1:0] seq_seed0 [3] = '{1, 2, 4};
`endif

    initial begin : stimulus
        logic [SIG_W-1:0] s;

        bus.start        = 1'b0;
        bus.num_patterns = '0;
        bus.seed         = '0;

        // Reset state.
        #3;
        check("reset pat_out",   32'(bus.pat_out),   32'd0);
        check("reset signature", 32'(bus.signature), 32'd0);
        check("reset pat_count", 32'(bus.pat_count), 32'd0);
        check("reset busy",      32'(bus.busy),      32'd0);
        check("reset done",      32'(bus.done),      32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single pattern, constant response 3F.
        use_circuit = 1'b0;
        resp_const  = 6'h3F;
        exp_pats.push_back(4'd1);
        launch(4'd1, 8'd1, 16'h003F, 1'b1);
        wait_done();

        // Two patterns: 3F, then (3F<<1)^3F = 41.
        exp_pats.push_back(4'd1);
        exp_pats.push_back(4'd2);
        launch(4'd1, 8'd2, 16'h0041, 1'b1);
        wait_done();

        // Full 15-pattern run through the emulated circuit; start pulsed mid-run.
        use_circuit = 1'b1;
        s = '0;
        foreach (seq15[i]) begin
            exp_pats.push_back(seq15[i]);
            s = misr_step(s, circuit(seq15[i]));
        end
        launch(4'd1, 8'd15, s, 1'b1);
        @(posedge clk);
        #1 bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        wait_done();
        check("pat_out after 15-run", 32'(bus.pat_out), 32'(NEXT_AFTER_15));

        // Zero-length run clears the signature left by the previous run.
        launch(4'd3, 8'd0, 16'h0000, 1'b1);
        wait_done();
        check("zero-run pat_count", 32'(bus.pat_count), 32'd0);

        // Seed 0 handling, three compactions of 3F: 3F, 41, BD.
        use_circuit = 1'b0;
        foreach (seq_seed0[i]) exp_pats.push_back(seq_seed0[i]);
        launch(4'd0, 8'd3, 16'h00BD, 1'b1);
        wait_done();

        // Reset during the 5th RUN cycle of a 20-pattern run.
        exp_pats.push_back(4'd1);
        exp_pats.push_back(4'd2);
`ifdef HARNESS_EXHAUSTIVE_EN
        exp_pats.push_back(4'd3);
        exp_pats.push_back(4'd4);
`else
        exp_pats.push_back(4'd4);
        exp_pats.push_back(4'd9);
`endif
        launch(4'd1, 8'd20, 16'h0000, 1'b0);
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort busy",      32'(bus.busy),      32'd0);
        check("abort done",      32'(bus.done),      32'd0);
        check("abort pat_out",   32'(bus.pat_out),   32'd0);
        check("abort signature", 32'(bus.signature), 32'd0);
        check("abort pat_count", 32'(bus.pat_count), 32'd0);
        check("abort patterns consumed", exp_pats.size(), 0);
        exp_pats.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Normal run after the abort.
        exp_pats.push_back(4'd1);
        exp_pats.push_back(4'd2);
        launch(4'd1, 8'd2, 16'h0041, 1'b1);
        wait_done();

`ifdef HARNESS_EXHAUSTIVE_EN
        // Exhaustive sweep from seed 0 through the emulated circuit.
        use_circuit = 1'b1;
        s = '0;
        for (int i = 0; i < 16; i++) begin
            exp_pats.push_back(PAT_W'(i));
            s = misr_step(s, circuit(PAT_W'(i)));
        end
        launch(4'd0, 8'd16, s, 1'b1);
        wait_done();
`endif

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pattern_misr_harness.md
PATTERN_MISR_HARNESS -- requirements
Module: pattern_misr_harness

Interface
REQ-001 SHALL have parameter PAT_W, default 4, meaning the pattern width driven to the circuit inputs x[PAT_W-1:0].
REQ-002 SHALL have parameter RESP_W, default 6, meaning the response width captured from the circuit outputs f[RESP_W:1].
REQ-003 SHALL have parameter SIG_W, default 16, meaning the MISR signature width (SIG_W >= RESP_W).
REQ-004 SHALL have parameter CNT_W, default 8, meaning the pattern counter width.
REQ-005 SHALL use one clock and an asynchronous, active-low reset.
REQ-006 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-008 SHALL have port start, input, 1 bit: begin a run; honoured only in IDLE.
REQ-009 SHALL have port num_patterns, input, CNT_W bits: patterns per run, latched at start.
REQ-010 SHALL have port seed, input, PAT_W bits: first pattern, latched at start.
REQ-011 SHALL have port pat_out, output, PAT_W bits: registered pattern driving the combinational circuit under test.
REQ-012 SHALL have port resp_in, input, RESP_W bits: circuit response to the current pat_out, same cycle.
REQ-013 SHALL have port busy, output, 1 bit: high in RUN.
REQ-014 SHALL have port done, output, 1 bit: one-cycle pulse in DONE.
REQ-015 SHALL have port signature, output, SIG_W bits: MISR state, held stable outside RUN.
REQ-016 SHALL have port pat_count, output, CNT_W bits: patterns compacted in the current or last run.

Function
REQ-017 SHALL implement FSM states IDLE, RUN and DONE.
REQ-018 In IDLE, start=1 with num_patterns!=0 SHALL do all of the following and go to RUN: latch num_patterns; load pat_out=seed (LFSR mode: seed==0 replaced by 1); clear signature and pat_count.
REQ-019 In IDLE, start=1 with num_patterns==0 SHALL clear signature and pat_count and go to DONE.
REQ-020 Each RUN cycle SHALL set sig <= {sig[SIG_W-2:0],1'b0} ^ (sig[SIG_W-1] ? 16'h1021 : 0) ^ zero-extended resp_in, advance pat_out, and increment pat_count.
REQ-021 RUN SHALL go to DONE in the cycle pat_count reaches the latched count, giving exactly num_patterns compactions.
REQ-022 LFSR mode: next pattern = {p[2:0], p[3]^p[2]}, giving period 15 that never emits 0.
REQ-023 DONE SHALL assert done for exactly one cycle, then go to IDLE.
REQ-024 start in RUN or DONE SHALL be ignored; num_patterns and seed changes after start SHALL have no effect.
REQ-025 pat_count SHALL wrap at 2^CNT_W but cannot exceed the latched count.

Reset
REQ-026 rst_n low SHALL immediately force state IDLE, pat_out=0, signature=0, pat_count=0, busy=0 and done=0, including mid-run; the aborted run SHALL produce no done.

Configuration
REQ-027 With HARNESS_EXHAUSTIVE_EN defined, pat_out SHALL advance as a binary up-counter modulo 2^PAT_W from seed, with seed 0 allowed, covering all 16 patterns in 16 cycles.
REQ-028 Without HARNESS_EXHAUSTIVE_EN, pat_out SHALL advance per REQ-022.

Structure
REQ-029 A shared package SHALL hold the state enum, MISR polynomial constant 16'h1021 and LFSR tap constant.
REQ-030 Sub-module pattern_gen SHALL contain the pattern register and its LFSR/counter selection; the MISR and FSM SHALL stay in the top.

Verification
REQ-031 seed=1, num=1, resp_in=6'h3F -> one busy cycle, done pulse, signature=16'h003F, pat_count=1.
REQ-032 seed=1, num=2, resp_in=6'h3F constant -> signature=16'h0041.
REQ-033 LFSR mode, seed=1, num=15 -> pat_out sequence 1,2,4,9,3,6,13,10,5,11,7,15,14,12,8; next pattern would be 1.
REQ-034 num=0 with start -> done one cycle later, signature=0, busy never high.
REQ-035 rst_n low in the 5th RUN cycle of num=20 -> all outputs 0 asynchronously, no done; a new start then runs normally.
REQ-036 HARNESS_EXHAUSTIVE_EN, seed=0, num=16, resp_in tied to a golden model of the circuit -> pat_out 0..15, signature matches the model.
